// File: rtl/npc_mem_arbiter_if.sv
// Bus bundle for npc_mem_arbiter: IFU/LSU requester ports, shared memory port and error flag.
// slave is the arbiter's view; master is the core / memory-model side.
interface npc_mem_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [63:0] ifu_req_addr;
  logic        ifu_rsp_valid;
  logic [63:0] ifu_rsp_data;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [63:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [63:0] lsu_req_wdata;
  logic [7:0]  lsu_req_wmask;
  logic        lsu_rsp_valid;
  logic [63:0] lsu_rsp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        err_timeout;

  modport slave (
    input  ifu_req_valid, ifu_req_addr,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output err_timeout
  );

  modport master (
    output ifu_req_valid, ifu_req_addr,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  err_timeout
  );
endinterface

// File: rtl/npc_mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction outstanding at a time.
// Define NPC_ARB_RR_EN for strict round-robin; default is LSU priority with an IFU starvation escape.
module npc_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic               clk,
  input logic               rst,
  npc_mem_arbiter_if.slave  bus
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e          state_q, state_d;
  logic            owner_lsu_q, owner_lsu_d;
  logic [63:0]     addr_q, addr_d;
  logic            wen_q, wen_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [7:0]      wmask_q, wmask_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            ifu_rsp_valid_q, ifu_rsp_valid_d;
  logic [63:0]     ifu_rsp_data_q, ifu_rsp_data_d;
  logic            lsu_rsp_valid_q, lsu_rsp_valid_d;
  logic [63:0]     lsu_rsp_data_q, lsu_rsp_data_d;
  logic            err_q, err_d;
  logic            grant_ifu, grant_lsu;
  logic [63:0]     rsp_word;
`ifdef NPC_ARB_RR_EN
  logic            last_lsu_q, last_lsu_d;
`else
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0]   starve_q, starve_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      owner_lsu_q     <= 1'b0;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      tmo_q           <= '0;
      ifu_rsp_valid_q <= 1'b0;
      ifu_rsp_data_q  <= '0;
      lsu_rsp_valid_q <= 1'b0;
      lsu_rsp_data_q  <= '0;
      err_q           <= 1'b0;
`ifdef NPC_ARB_RR_EN
      last_lsu_q      <= 1'b1;
`else
      starve_q        <= '0;
`endif
    end else begin
      state_q         <= state_d;
      owner_lsu_q     <= owner_lsu_d;
      addr_q          <= addr_d;
      wen_q           <= wen_d;
      wdata_q         <= wdata_d;
      wmask_q         <= wmask_d;
      tmo_q           <= tmo_d;
      ifu_rsp_valid_q <= ifu_rsp_valid_d;
      ifu_rsp_data_q  <= ifu_rsp_data_d;
      lsu_rsp_valid_q <= lsu_rsp_valid_d;
      lsu_rsp_data_q  <= lsu_rsp_data_d;
      err_q           <= err_d;
`ifdef NPC_ARB_RR_EN
      last_lsu_q      <= last_lsu_d;
`else
      starve_q        <= starve_d;
`endif
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_lsu_d     = owner_lsu_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    tmo_d           = tmo_q;
    ifu_rsp_valid_d = 1'b0;
    ifu_rsp_data_d  = ifu_rsp_data_q;
    lsu_rsp_valid_d = 1'b0;
    lsu_rsp_data_d  = lsu_rsp_data_q;
    err_d           = err_q;
    rsp_word        = '0;
`ifdef NPC_ARB_RR_EN
    last_lsu_d      = last_lsu_q;
`else
    starve_d        = starve_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_ifu) begin
          state_d     = REQ;
          owner_lsu_d = 1'b0;
          addr_d      = bus.ifu_req_addr;
          wen_d       = 1'b0;
          wdata_d     = '0;
          wmask_d     = '0;
`ifdef NPC_ARB_RR_EN
          last_lsu_d  = 1'b0;
`else
          starve_d    = '0;
`endif
        end else if (grant_lsu) begin
          state_d     = REQ;
          owner_lsu_d = 1'b1;
          addr_d      = bus.lsu_req_addr;
          wen_d       = bus.lsu_req_wen;
          wdata_d     = bus.lsu_req_wdata;
          wmask_d     = bus.lsu_req_wen ? bus.lsu_req_wmask : 8'h00;
`ifdef NPC_ARB_RR_EN
          last_lsu_d  = 1'b1;
`else
          if (bus.ifu_req_valid && (starve_q != SW'(STARVE_MAX)))
            starve_d = starve_q + SW'(1);
`endif
        end
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          state_d = RESP;
          tmo_d   = '0;
        end
      end
      RESP: begin
        tmo_d = tmo_q + TW'(1);
        // A response arriving on the timeout cycle still counts as a normal completion.
        if (bus.mem_rsp_valid || (tmo_q == TW'(TIMEOUT))) begin
          state_d  = IDLE;
          rsp_word = bus.mem_rsp_valid ? bus.mem_rsp_data : 64'h0;
          err_d    = err_q | ~bus.mem_rsp_valid;
          if (owner_lsu_q) begin
            lsu_rsp_valid_d = 1'b1;
            lsu_rsp_data_d  = wen_q ? 64'h0 : rsp_word;
          end else begin
            ifu_rsp_valid_d = 1'b1;
            ifu_rsp_data_d  = rsp_word;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if ((state_q == IDLE) && !rst) begin
`ifdef NPC_ARB_RR_EN
      if (bus.ifu_req_valid && bus.lsu_req_valid) begin
        grant_ifu = last_lsu_q;
        grant_lsu = ~last_lsu_q;
      end else begin
        grant_ifu = bus.ifu_req_valid;
        grant_lsu = bus.lsu_req_valid;
      end
`else
      if (bus.ifu_req_valid && (!bus.lsu_req_valid || (starve_q == SW'(STARVE_MAX))))
        grant_ifu = 1'b1;
      else
        grant_lsu = bus.lsu_req_valid;
`endif
    end
    bus.ifu_req_ready = grant_ifu;
    bus.lsu_req_ready = grant_lsu;
    bus.mem_req_valid = (state_q == REQ);
    bus.mem_req_addr  = addr_q;
    bus.mem_req_wen   = wen_q;
    bus.mem_req_wdata = wdata_q;
    bus.mem_req_wmask = wmask_q;
    bus.ifu_rsp_valid = ifu_rsp_valid_q;
    bus.ifu_rsp_data  = ifu_rsp_data_q;
    bus.lsu_rsp_valid = lsu_rsp_valid_q;
    bus.lsu_rsp_data  = lsu_rsp_data_q;
    bus.err_timeout   = err_q;
  end
endmodule

// File: tb/tb_npc_mem_arbiter.sv
// Self-checking bench for npc_mem_arbiter: vector table, arbitration/timeout/reset sequences,
// and a response scoreboard fed at each request handshake.
module tb_npc_mem_arbiter;
  localparam int TIMEOUT = 255;
  localparam int NV      = 5;

  typedef struct {
    logic        is_lsu;
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    int          ready_delay;
    int          rsp_delay;
    logic        exp_wen;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wmask;
    logic [63:0] exp_rsp;
  } vec_t;

  typedef struct {
    logic        is_lsu;
    logic [63:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   failures;
  vec_t vecs[NV];
  exp_t exp_q[$];

  npc_mem_arbiter_if bus();

  npc_mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_req_valid"}, bus.mem_req_valid, 0);
    checkOutput({tag, "_readies"}, {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
    checkOutput({tag, "_rsp_valids"}, {bus.ifu_rsp_valid, bus.lsu_rsp_valid}, 0);
    checkOutput({tag, "_rsp_data"}, bus.ifu_rsp_data | bus.lsu_rsp_data, 0);
    checkOutput({tag, "_mem_payload"}, bus.mem_req_addr | bus.mem_req_wdata |
                {55'h0, bus.mem_req_wen, bus.mem_req_wmask}, 0);
    checkOutput({tag, "_err_timeout"}, bus.err_timeout, 0);
  endtask

  // Scoreboard: every response pulse must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.ifu_rsp_valid || bus.lsu_rsp_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          failures++;
          $display("[TB] FAIL rsp_unexpected: got ifu=%0b lsu=%0b, expected no response",
                   bus.ifu_rsp_valid, bus.lsu_rsp_valid);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_rsp_source", {bus.ifu_rsp_valid, bus.lsu_rsp_valid},
                      e.is_lsu ? 64'd1 : 64'd2);
          checkOutput("sb_rsp_data", e.is_lsu ? bus.lsu_rsp_data : bus.ifu_rsp_data, e.data);
        end
      end
    end
  end

  task automatic applyStimulus(input vec_t v, input string tag);
    int   n;
    logic rdy;
    @(negedge clk);
    if (v.is_lsu) begin
      bus.lsu_req_valid = 1'b1;
      bus.lsu_req_addr  = v.addr;
      bus.lsu_req_wen   = v.wen;
      bus.lsu_req_wdata = v.wdata;
      bus.lsu_req_wmask = v.wmask;
    end else begin
      bus.ifu_req_valid = 1'b1;
      bus.ifu_req_addr  = v.addr;
    end
    #1;
    n   = 0;
    rdy = v.is_lsu ? bus.lsu_req_ready : bus.ifu_req_ready;
    while (!rdy && n < 50) begin
      @(negedge clk);
      #1;
      n++;
      rdy = v.is_lsu ? bus.lsu_req_ready : bus.ifu_req_ready;
    end
    checkOutput({tag, "_req_ready"}, rdy, 1);
    if (!rdy) begin
      bus.ifu_req_valid = 1'b0;
      bus.lsu_req_valid = 1'b0;
      return;
    end
    exp_q.push_back('{is_lsu: v.is_lsu, data: v.exp_rsp});
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    #1;
    checkOutput({tag, "_mem_req_valid"}, bus.mem_req_valid, 1);
    checkOutput({tag, "_mem_req_addr"}, bus.mem_req_addr, v.addr);
    checkOutput({tag, "_mem_req_wen"}, bus.mem_req_wen, v.exp_wen);
    checkOutput({tag, "_mem_req_wdata"}, bus.mem_req_wdata, v.exp_wdata);
    checkOutput({tag, "_mem_req_wmask"}, bus.mem_req_wmask, v.exp_wmask);
    // While memory stalls, also poke a stray response that must be ignored in REQ.
    for (int i = 0; i < v.ready_delay; i++) begin
      bus.mem_rsp_valid = (i == 2);
      bus.mem_rsp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      #1;
      checkOutput({tag, "_hold_valid"}, bus.mem_req_valid, 1);
      checkOutput({tag, "_hold_addr"}, bus.mem_req_addr, v.addr);
      checkOutput({tag, "_hold_wdata"}, bus.mem_req_wdata, v.exp_wdata);
      checkOutput({tag, "_hold_no_ready"}, {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
    end
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    repeat (v.rsp_delay) @(negedge clk);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = v.rdata;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    #1;
    checkOutput({tag, "_rsp_valid"}, v.is_lsu ? bus.lsu_rsp_valid : bus.ifu_rsp_valid, 1);
    @(negedge clk);
    #1;
    checkOutput({tag, "_rsp_pulse_end"}, {bus.ifu_rsp_valid, bus.lsu_rsp_valid}, 0);
  endtask

  initial begin
    int   n;
    int   k;
    logic seen;
    logic exp_lsu;
    logic prev_lsu;
    logic rdy_i;
    logic rdy_l;

    tests    = 0;
    failures = 0;

    vecs[0] = '{is_lsu: 1'b0, addr: 64'h8000_0000, wen: 1'b0, wdata: 64'h0, wmask: 8'h00,
                rdata: 64'h0010_0073, ready_delay: 0, rsp_delay: 1,
                exp_wen: 1'b0, exp_wdata: 64'h0, exp_wmask: 8'h00, exp_rsp: 64'h0010_0073};
    vecs[1] = '{is_lsu: 1'b1, addr: 64'h8000_1000, wen: 1'b1, wdata: 64'h1122_3344_5566_7788,
                wmask: 8'hFF, rdata: 64'hDEAD_BEEF, ready_delay: 0, rsp_delay: 0,
                exp_wen: 1'b1, exp_wdata: 64'h1122_3344_5566_7788, exp_wmask: 8'hFF, exp_rsp: 64'h0};
    vecs[2] = '{is_lsu: 1'b1, addr: 64'h8000_2008, wen: 1'b0, wdata: 64'hAAAA, wmask: 8'h0F,
                rdata: 64'h0123_4567_89AB_CDEF, ready_delay: 10, rsp_delay: 0,
                exp_wen: 1'b0, exp_wdata: 64'hAAAA, exp_wmask: 8'h00, exp_rsp: 64'h0123_4567_89AB_CDEF};
    vecs[3] = '{is_lsu: 1'b0, addr: 64'h8000_0004, wen: 1'b0, wdata: 64'h0, wmask: 8'h00,
                rdata: 64'h0000_0013, ready_delay: 2, rsp_delay: 6,
                exp_wen: 1'b0, exp_wdata: 64'h0, exp_wmask: 8'h00, exp_rsp: 64'h0000_0013};
    vecs[4] = '{is_lsu: 1'b1, addr: 64'h8000_3000, wen: 1'b1, wdata: 64'hCAFE_F00D_0000_0000,
                wmask: 8'hF0, rdata: 64'h5555, ready_delay: 1, rsp_delay: 3,
                exp_wen: 1'b1, exp_wdata: 64'hCAFE_F00D_0000_0000, exp_wmask: 8'hF0, exp_rsp: 64'h0};

    rst               = 1'b1;
    bus.ifu_req_valid = 1'b0;
    bus.ifu_req_addr  = '0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_req_addr  = '0;
    bus.lsu_req_wen   = 1'b0;
    bus.lsu_req_wdata = '0;
    bus.lsu_req_wmask = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkAllZero("reset");

    for (int i = 0; i < NV; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Both requesters valid back-to-back; record who wins each grant.
    prev_lsu = vecs[NV-1].is_lsu;
    @(negedge clk);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 64'h8000_0100;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 64'h8000_8000;
    bus.lsu_req_wen   = 1'b0;
    bus.lsu_req_wmask = 8'h00;
    #1;
    for (int i = 0; i < 10; i++) begin
`ifdef NPC_ARB_RR_EN
      exp_lsu = ~prev_lsu;
`else
      exp_lsu = (i % 5) != 4;
`endif
      n = 0;
      while (!(bus.ifu_req_ready || bus.lsu_req_ready) && n < 50) begin
        @(negedge clk);
        #1;
        n++;
      end
      rdy_i = bus.ifu_req_ready;
      rdy_l = bus.lsu_req_ready;
      checkOutput($sformatf("t3_grant%0d", i), {rdy_i, rdy_l}, exp_lsu ? 64'd1 : 64'd2);
      prev_lsu = exp_lsu;
      exp_q.push_back('{is_lsu: rdy_l, data: 64'h1000 + 64'(i)});
      @(negedge clk);
      #1;
      checkOutput($sformatf("t3_addr%0d", i), bus.mem_req_addr,
                  exp_lsu ? 64'h8000_8000 : 64'h8000_0100);
      checkOutput($sformatf("t3_no_ready_req%0d", i), {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      #1;
      checkOutput($sformatf("t3_no_ready_resp%0d", i), {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 64'h1000 + 64'(i);
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      #1;
    end
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Memory never answers: abort after TIMEOUT cycles in RESP.
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 64'h8000_0040;
    #1;
    checkOutput("t5_req_ready", bus.ifu_req_ready, 1);
    exp_q.push_back('{is_lsu: 1'b0, data: 64'h0});
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < TIMEOUT + 20) begin
      #1;
      if (bus.ifu_rsp_valid) seen = 1'b1;
      else begin
        if (k == TIMEOUT) checkOutput("t5_err_before", bus.err_timeout, 0);
        @(negedge clk);
        k++;
      end
    end
    checkOutput("t5_latency", 64'(k), 64'(TIMEOUT + 1));
    checkOutput("t5_err_set", bus.err_timeout, 1);
    checkOutput("t5_rsp_data", bus.ifu_rsp_data, 0);
    checkOutput("t5_lsu_quiet", bus.lsu_rsp_valid, 0);
    applyStimulus(vecs[0], "t5_after");
    checkOutput("t5_err_sticky", bus.err_timeout, 1);

    // Reset while waiting in RESP, then a late response that must be dropped.
    @(negedge clk);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 64'h8000_0200;
    #1;
    checkOutput("t6_req_ready", bus.ifu_req_ready, 1);
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkAllZero("t6_after_rst");
    repeat (2) @(negedge clk);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'hBADB_AD00;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    #1;
    checkOutput("t6_late_rsp_dropped", {bus.ifu_rsp_valid, bus.lsu_rsp_valid}, 0);
    @(negedge clk);
    #1;
    checkOutput("t6_still_quiet", {bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid}, 0);
    applyStimulus(vecs[3], "t6_next_ifu");

    // Response lands on the very cycle the timeout would fire: response wins.
    @(negedge clk);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 64'h8000_0300;
    #1;
    checkOutput("race_req_ready", bus.ifu_req_ready, 1);
    exp_q.push_back('{is_lsu: 1'b0, data: 64'h600D});
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    repeat (TIMEOUT) @(negedge clk);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'h600D;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    #1;
    checkOutput("race_rsp_valid", bus.ifu_rsp_valid, 1);
    checkOutput("race_rsp_data", bus.ifu_rsp_data, 64'h600D);
    checkOutput("race_err_clear", bus.err_timeout, 0);

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
